// File: rtl/nonce_scanner.sv
// nonce_scanner
//   Drives a sha256d_wrapper. It holds a 19-word block header in a small
//   register RAM and serves it over the wrapper's addr/rdy/data fetch bus. Word
//   19 is replaced by the live nonce in little-endian byte order. For each
//   nonce the block pulses sha_start and waits for the wrapper's digest. It
//   then checks the byte-reversed digest against a leading-zero difficulty.
//   The scan runs from nonce_start to nonce_end inclusive, wrapping through
//   0xFFFFFFFF. It ends on a hit, when the range is exhausted, or on a stop
//   request. A stop request is only honoured between hashes.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   hdr_we/hdr_waddr/hdr_wdata  host header word write (idle only, words 0..18)
//   nonce_start, nonce_end  inclusive scan range, sampled on go
//   diff_bits               required leading zero bits of the LE hash, sampled on go
//   go, stop                start scan (idle only) / abort at next hash boundary
//   sha_addr, sha_rq        wrapper fetch address and fetch indicator
//   sha_rdy, sha_data       header word to the wrapper (valid in START and WAIT)
//   sha_start               one-cycle start pulse to the wrapper
//   sha_hash, sha_done      wrapper digest {H0..H7} and level-sticky done
//   busy, found, exhausted  scan status; found/exhausted stay set until the next go
//   found_nonce, found_hash nonce and raw digest of the hit
//   hash_count              hashes completed in the current or last scan
module nonce_scanner (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hdr_we,
  input  logic [4:0]   hdr_waddr,
  input  logic [31:0]  hdr_wdata,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [7:0]   diff_bits,
  input  logic         go,
  input  logic         stop,
  input  logic [4:0]   sha_addr,
  input  logic         sha_rq,
  output logic         sha_rdy,
  output logic [31:0]  sha_data,
  output logic         sha_start,
  input  logic [255:0] sha_hash,
  input  logic         sha_done,
  output logic         busy,
  output logic         found,
  output logic         exhausted,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
  output logic [31:0]  hash_count
);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, CHECK} state_t;

  state_t         state_reg, state_next;
  logic [31:0]    hdr_mem [0:18];
  logic [31:0]    nonce_reg, nonce_end_reg;
  logic [7:0]     diff_reg;
  logic           stop_seen_reg;
  logic           done_d_reg, rq_d_reg;
  logic [5:0]     fetch_cnt_reg;
  logic [255:0]   hash_reg;
  logic           found_reg, exhausted_reg;
  logic [31:0]    found_nonce_reg, hash_count_reg;
  logic [255:0]   found_hash_reg;

  logic [255:0]   hash_le, diff_mask;
  logic           done_rise, rq_rise, hit, last_nonce;

  // The wrapper holds sha_done high after finishing, so only its rising edge
  // marks a new digest.
  assign done_rise  = sha_done & ~done_d_reg;
  assign rq_rise    = sha_rq & ~rq_d_reg;
  assign last_nonce = (nonce_reg == nonce_end_reg);

  // The digest byte sha_hash[7:0] is the most significant byte of the
  // little-endian hash, so reverse the whole digest byte by byte.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_bswap
      assign hash_le[8*gi +: 8] = hash_reg[255-8*gi -: 8];
    end
  endgenerate

  // Mask of the top diff_bits bits. diff_bits = 0 gives an empty mask, so
  // every hash counts as a hit.
  assign diff_mask = ~({256{1'b1}} >> diff_reg);
  assign hit       = ((hash_le & diff_mask) == '0);

  // The fetch bus is combinational from the wrapper's address.
  always_comb begin
    sha_data = 32'h0;
    if (sha_addr < 5'd19)
      sha_data = hdr_mem[sha_addr];
    else if (sha_addr == 5'd19)
      sha_data = {nonce_reg[7:0], nonce_reg[15:8], nonce_reg[23:16], nonce_reg[31:24]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    sha_start  = 1'b0;
    sha_rdy    = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (go) state_next = LOAD;
      end
      LOAD:  state_next = START;
      START: begin
        sha_start  = 1'b1;
        sha_rdy    = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        sha_rdy = 1'b1;
        if (done_rise) state_next = CHECK;
      end
      CHECK: begin
        if (hit || last_nonce || stop_seen_reg)
          state_next = IDLE;
        else
          state_next = START;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 19; i++) hdr_mem[i] <= '0;
      nonce_reg       <= '0;
      nonce_end_reg   <= '0;
      diff_reg        <= '0;
      stop_seen_reg   <= 1'b0;
      done_d_reg      <= 1'b0;
      rq_d_reg        <= 1'b0;
      fetch_cnt_reg   <= '0;
      hash_reg        <= '0;
      found_reg       <= 1'b0;
      exhausted_reg   <= 1'b0;
      found_nonce_reg <= '0;
      found_hash_reg  <= '0;
      hash_count_reg  <= '0;
    end else begin
      done_d_reg <= sha_done;
      rq_d_reg   <= sha_rq;

      // Fetches are counted only while a hash is in flight.
      if (state_reg == START || state_reg == WAIT)
        fetch_cnt_reg <= fetch_cnt_reg + {5'd0, rq_rise};
      else
        fetch_cnt_reg <= '0;

      if (state_reg == IDLE) begin
        if (hdr_we && hdr_waddr < 5'd19)
          hdr_mem[hdr_waddr] <= hdr_wdata;
        if (go) begin
          nonce_reg      <= nonce_start;
          nonce_end_reg  <= nonce_end;
          diff_reg       <= diff_bits;
          // A stop arriving together with go ends the scan after one hash.
          stop_seen_reg  <= stop;
          found_reg      <= 1'b0;
          exhausted_reg  <= 1'b0;
          hash_count_reg <= '0;
        end
      end else begin
        stop_seen_reg <= stop_seen_reg | stop;
      end

      if (state_reg == WAIT && done_rise)
        hash_reg <= sha_hash;

      if (state_reg == CHECK) begin
        hash_count_reg <= hash_count_reg + 32'd1;
        if (hit) begin
          found_reg       <= 1'b1;
          found_nonce_reg <= nonce_reg;
          found_hash_reg  <= hash_reg;
        end else if (last_nonce) begin
          exhausted_reg <= 1'b1;
        end else if (!stop_seen_reg) begin
          nonce_reg <= nonce_reg + 32'd1;
        end
      end
    end
  end

  // Each hash must fetch exactly 20 header words.
  always @(posedge clk) begin
    if (rst_n && state_reg == WAIT && done_rise)
      assert (fetch_cnt_reg == 6'd20);
  end

  assign found       = found_reg;
  assign exhausted   = exhausted_reg;
  assign found_nonce = found_nonce_reg;
  assign found_hash  = found_hash_reg;
  assign hash_count  = hash_count_reg;

endmodule

// File: tb/tb_nonce_scanner.sv
// tb_nonce_scanner
//   Directed bench for nonce_scanner. A behavioural stand-in for the
//   sha256d_wrapper fetches all 20 words per hash and checks each one. It then
//   returns a chosen digest and raises a level-sticky done. The genesis nonce
//   gets the real genesis digest. Every other nonce gets a digest whose
//   little-endian form has exactly 31 leading zero bits.
module tb_nonce_scanner;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         hdr_we = 1'b0;
  logic [4:0]   hdr_waddr = '0;
  logic [31:0]  hdr_wdata = '0;
  logic [31:0]  nonce_start = '0;
  logic [31:0]  nonce_end = '0;
  logic [7:0]   diff_bits = '0;
  logic         go = 1'b0;
  logic         stop = 1'b0;
  logic [4:0]   sha_addr;
  logic         sha_rq = 1'b0;
  logic         sha_rdy;
  logic [31:0]  sha_data;
  logic         sha_start;
  logic [255:0] sha_hash = '0;
  logic         sha_done = 1'b0;
  logic         busy, found, exhausted;
  logic [31:0]  found_nonce, hash_count;
  logic [255:0] found_hash;

  localparam logic [31:0]  GEN_NONCE   = 32'h7C2BAC1D;
  localparam logic [255:0] GENESIS_RAW =
    256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
  localparam logic [255:0] NEAR_RAW = {{224{1'b1}}, 32'h0100_0000};

  int checks = 0;
  int errors = 0;

  logic [31:0] gen_hdr   [0:18];
  logic [31:0] hdr_model [0:18];

  // Wrapper model state.
  logic        m_active = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [4:0]  t_addr = '0;
  int          m_phase = 0;
  int          m_idx = 0;
  int          hash_idx = 0;
  logic [31:0] exp_nonce = '0;
  logic [31:0] exp_word;

  assign sha_addr = m_active ? m_addr : t_addr;

  nonce_scanner dut (
    .clk(clk), .rst_n(rst_n),
    .hdr_we(hdr_we), .hdr_waddr(hdr_waddr), .hdr_wdata(hdr_wdata),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .diff_bits(diff_bits),
    .go(go), .stop(stop),
    .sha_addr(sha_addr), .sha_rq(sha_rq), .sha_rdy(sha_rdy), .sha_data(sha_data),
    .sha_start(sha_start), .sha_hash(sha_hash), .sha_done(sha_done),
    .busy(busy), .found(found), .exhausted(exhausted),
    .found_nonce(found_nonce), .found_hash(found_hash), .hash_count(hash_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bswap(input logic [31:0] n);
    return {n[7:0], n[15:8], n[23:16], n[31:24]};
  endfunction

  function automatic logic [255:0] hash_for(input logic [31:0] n);
    if (n == GEN_NONCE) return GENESIS_RAW;
    return NEAR_RAW;
  endfunction

  // Wrapper stand-in: one fetch every two cycles, 20 fetches, then done.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_phase  = 0;
      m_active = 1'b0;
      m_idx    = 0;
      sha_rq   = 1'b0;
      sha_done = 1'b0;
    end else begin
      case (m_phase)
        0: if (sha_start === 1'b1) begin
             sha_done = 1'b0;
             m_active = 1'b1;
             m_idx    = 0;
             m_phase  = 1;
           end
        1: begin
             m_addr = m_idx[4:0];
             sha_rq = 1'b1;
             #1;
             if (m_idx < 19) exp_word = hdr_model[m_idx];
             else            exp_word = bswap(exp_nonce);
             checks++;
             if (sha_rdy !== 1'b1 || sha_data !== exp_word) begin
               errors++;
               $display("FAIL fetch word %0d hash %0d: rdy=%b data=%h, expected rdy=1 data=%h",
                        m_idx, hash_idx, sha_rdy, sha_data, exp_word);
             end
             m_phase = 2;
           end
        2: begin
             sha_rq = 1'b0;
             m_idx++;
             m_phase = (m_idx == 20) ? 3 : 1;
           end
        default: begin
             sha_hash = hash_for(exp_nonce);
             sha_done = 1'b1;
             exp_nonce++;
             hash_idx++;
             m_active = 1'b0;
             m_phase  = 0;
           end
      endcase
    end
  end

  task automatic write_hdr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    hdr_we = 1'b1; hdr_waddr = a; hdr_wdata = d;
    @(negedge clk);
    hdr_we = 1'b0;
  endtask

  task automatic load_header();
    for (int i = 0; i < 19; i++) begin
      write_hdr(5'(i), gen_hdr[i]);
      hdr_model[i] = gen_hdr[i];
    end
    write_hdr(5'd19, 32'hCAFEBABE);
    write_hdr(5'd31, 32'h12345678);
  endtask

  task automatic start_scan(input logic [31:0] s, input logic [31:0] e, input logic [7:0] d,
                            input logic with_stop);
    @(negedge clk);
    nonce_start = s; nonce_end = e; diff_bits = d; exp_nonce = s;
    go = 1'b1; stop = with_stop;
    @(negedge clk);
    go = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s timeout: busy=%b after %0d cycles, expected 0", name, busy, n);
    end
    $display("scan %s: found=%b exhausted=%b found_nonce=%h hash_count=%0d",
             name, found, exhausted, found_nonce, hash_count);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, found, exhausted, sha_rdy, sha_start} !== 5'b0 || found_nonce !== 32'h0 ||
        hash_count !== 32'h0 || found_hash !== 256'h0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b found=%b exh=%b rdy=%b start=%b fn=%h hc=%0d, expected all 0",
               busy, found, exhausted, sha_rdy, sha_start, found_nonce, hash_count);
    end
    t_addr = 5'd0; #1;
    checks++;
    if (sha_data !== 32'h0) begin
      errors++; $display("FAIL reset_header: data=%h expected 0", sha_data);
    end
    $display("reset check done");
  endtask

  task automatic test_bus_idle();
    t_addr = 5'd0; #1;
    checks++;
    if (sha_data !== gen_hdr[0]) begin
      errors++; $display("FAIL idle_word0: data=%h expected %h", sha_data, gen_hdr[0]);
    end
    t_addr = 5'd19; #1;
    checks++;
    if (sha_data !== 32'h0) begin
      errors++; $display("FAIL idle_word19: data=%h expected 0 (nonce 0, write ignored)", sha_data);
    end
    t_addr = 5'd25; #1;
    checks++;
    if (sha_data !== 32'h0 || sha_rdy !== 1'b0) begin
      errors++; $display("FAIL idle_word25: data=%h rdy=%b expected 0/0", sha_data, sha_rdy);
    end
    $display("idle bus check done");
  endtask

  task automatic test_genesis();
    start_scan(GEN_NONCE, GEN_NONCE, 8'd32, 1'b0);
    wait_idle("genesis");
    checks++;
    if (found !== 1'b1 || exhausted !== 1'b0 || found_nonce !== GEN_NONCE || hash_count !== 32'd1) begin
      errors++;
      $display("FAIL genesis_result: found=%b exh=%b fn=%h hc=%0d expected 1 0 %h 1",
               found, exhausted, found_nonce, hash_count, GEN_NONCE);
    end
    checks++;
    if (found_hash[31:0] !== 32'h0 || found_hash !== GENESIS_RAW) begin
      errors++; $display("FAIL genesis_hash: got %h expected %h", found_hash, GENESIS_RAW);
    end
  endtask

  task automatic test_range_hit();
    start_scan(32'h7C2BAC10, GEN_NONCE, 8'd32, 1'b0);
    wait_idle("range_hit");
    checks++;
    if (found !== 1'b1 || exhausted !== 1'b0 || found_nonce !== GEN_NONCE || hash_count !== 32'd14) begin
      errors++;
      $display("FAIL range_hit: found=%b exh=%b fn=%h hc=%0d expected 1 0 %h 14",
               found, exhausted, found_nonce, hash_count, GEN_NONCE);
    end
    t_addr = 5'd19; #1;
    checks++;
    if (sha_data !== bswap(GEN_NONCE) || sha_rdy !== 1'b0) begin
      errors++; $display("FAIL range_hit_nonce_word: data=%h rdy=%b expected %h 0",
                         sha_data, sha_rdy, bswap(GEN_NONCE));
    end
  endtask

  task automatic test_exhaust();
    start_scan(32'd0, 32'd3, 8'd32, 1'b0);
    wait_idle("exhaust");
    checks++;
    if (found !== 1'b0 || exhausted !== 1'b1 || hash_count !== 32'd4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL exhaust: found=%b exh=%b hc=%0d busy=%b expected 0 1 4 0",
               found, exhausted, hash_count, busy);
    end
  endtask

  task automatic test_boundaries();
    start_scan(32'd5, 32'd9, 8'd0, 1'b0);
    wait_idle("diff0");
    checks++;
    if (found !== 1'b1 || found_nonce !== 32'd5 || hash_count !== 32'd1) begin
      errors++; $display("FAIL diff0: found=%b fn=%h hc=%0d expected 1 5 1",
                         found, found_nonce, hash_count);
    end
    start_scan(32'hFFFFFFFE, 32'd1, 8'd255, 1'b0);
    wait_idle("wrap");
    checks++;
    if (found !== 1'b0 || exhausted !== 1'b1 || hash_count !== 32'd4) begin
      errors++; $display("FAIL wrap: found=%b exh=%b hc=%0d expected 0 1 4",
                         found, exhausted, hash_count);
    end
    t_addr = 5'd19; #1;
    checks++;
    if (sha_data !== 32'h0100_0000) begin
      errors++; $display("FAIL wrap_last_nonce: data=%h expected 01000000", sha_data);
    end
    start_scan(32'd100, 32'd102, 8'd31, 1'b0);
    wait_idle("diff31");
    checks++;
    if (found !== 1'b1 || found_nonce !== 32'd100 || hash_count !== 32'd1 || found_hash !== NEAR_RAW) begin
      errors++; $display("FAIL diff31: found=%b fn=%h hc=%0d expected 1 100 1",
                         found, found_nonce, hash_count);
    end
  endtask

  task automatic test_stop();
    int base = hash_idx;
    int n = 0;
    start_scan(32'd100, 32'd200, 8'd32, 1'b0);
    while (!(hash_idx == base + 2 && m_phase == 1 && m_idx == 5) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++; $display("FAIL stop_wait timeout: hashes=%0d expected %0d", hash_idx - base, 2);
    end
    stop = 1'b1; go = 1'b1; nonce_start = 32'd500;
    hdr_we = 1'b1; hdr_waddr = 5'd3; hdr_wdata = 32'hDEADBEEF;
    @(negedge clk);
    stop = 1'b0; go = 1'b0; hdr_we = 1'b0;
    wait_idle("stop");
    checks++;
    if (found !== 1'b0 || exhausted !== 1'b0 || hash_count !== 32'd3) begin
      errors++; $display("FAIL stop: found=%b exh=%b hc=%0d expected 0 0 3",
                         found, exhausted, hash_count);
    end
    t_addr = 5'd3; #1;
    checks++;
    if (sha_data !== gen_hdr[3]) begin
      errors++; $display("FAIL busy_write: word3=%h expected %h", sha_data, gen_hdr[3]);
    end
    start_scan(32'd300, 32'd400, 8'd32, 1'b1);
    wait_idle("go_with_stop");
    checks++;
    if (found !== 1'b0 || exhausted !== 1'b0 || hash_count !== 32'd1) begin
      errors++; $display("FAIL go_with_stop: found=%b exh=%b hc=%0d expected 0 0 1",
                         found, exhausted, hash_count);
    end
  endtask

  task automatic test_reset_mid();
    int base = hash_idx;
    int n = 0;
    start_scan(32'd0, 32'd3, 8'd32, 1'b0);
    while (!(hash_idx == base + 1 && m_phase == 1 && m_idx == 10) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000 || hash_count !== 32'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL reset_mid_setup: hc=%0d busy=%b expected 1 1", hash_count, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || sha_rdy !== 1'b0 || hash_count !== 32'h0 || found_nonce !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b rdy=%b hc=%0d fn=%h expected 0 0 0 0",
               busy, sha_rdy, hash_count, found_nonce);
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 19; i++) hdr_model[i] = 32'h0;
    t_addr = 5'd9; #1;
    checks++;
    if (sha_data !== 32'h0) begin
      errors++; $display("FAIL reset_mid_header: word9=%h expected 0", sha_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    load_header();
    start_scan(32'h7C2BAC1B, 32'h7C2BAC1F, 8'd32, 1'b0);
    wait_idle("after_reset");
    checks++;
    if (found !== 1'b1 || found_nonce !== GEN_NONCE || hash_count !== 32'd3 || exhausted !== 1'b0) begin
      errors++; $display("FAIL after_reset: found=%b fn=%h hc=%0d exh=%b expected 1 %h 3 0",
                         found, found_nonce, hash_count, exhausted, GEN_NONCE);
    end
  endtask

  initial begin
    gen_hdr = '{32'h01000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61,
                32'h7fc81bc3, 32'h888a5132, 32'h3a9fb8aa, 32'h4b1e5e4a,
                32'h29ab5f49, 32'hffff001d};
    for (int i = 0; i < 19; i++) hdr_model[i] = 32'h0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    load_header();
    test_bus_idle();
    test_genesis();
    test_range_hit();
    test_exhaust();
    test_boundaries();
    test_stop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
